// File: rtl/if_id_stage.sv
// Instruction-fetch front end: PC, imem req/ack fetch, one-entry skid buffer and IF/ID register.
// Handles ID stall/flush and branch redirects, including a redirect over an outstanding fetch.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [15:0] id_imm16
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHold
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc4;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;

    logic        w_accept;
    logic        w_fetch_ack;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_accept    = !stall || !r_id_valid;
    assign w_fetch_ack = (r_state == StFetch) && imem_ack;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_target    = branch_target & 32'hFFFF_FFFC;

    // Request drops combinationally with reset so memory never sees a fetch during reset.
    assign imem_req  = rst_n && (r_state != StHold);
    assign imem_addr = (r_state == StDrain) ? r_drain_addr : r_pc;

    // Fetch FSM, PC and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StFetch;
            r_pc         <= RESET_PC_ALIGNED;
            r_drain_addr <= 32'h0;
            r_buf_instr  <= 32'h0;
            r_buf_pc4    <= 32'h0;
        end else if (branch_taken) begin
            r_pc <= w_target;
            unique case (r_state)
                StFetch: begin
                    if (!imem_ack) begin
                        r_drain_addr <= r_pc;
                        r_state      <= StDrain;
                    end
                end
                StHold:  r_state <= StFetch;
                // An ack here retires the old-path request, so no further drain is needed.
                StDrain: r_state <= imem_ack ? StFetch : StDrain;
                default: r_state <= StFetch;
            endcase
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (!w_accept || flush) begin
                            r_buf_instr <= imem_rdata;
                            r_buf_pc4   <= w_pc_plus4;
                            r_state     <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (w_accept && !flush) begin
                        r_state <= StFetch;
                    end
                end
                StDrain: begin
                    if (imem_ack) begin
                        r_state <= StFetch;
                    end
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    // IF/ID pipeline register; redirect and flush take priority over any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0;
            r_id_pc4   <= 32'h0;
        end else if (branch_taken || flush) begin
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0;
        end else if (w_accept) begin
            if (w_fetch_ack) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rdata;
                r_id_pc4   <= w_pc_plus4;
            end else if (r_state == StHold) begin
                r_id_valid <= 1'b1;
                r_id_instr <= r_buf_instr;
                r_id_pc4   <= r_buf_pc4;
            end else begin
                r_id_valid <= 1'b0;
            end
        end
    end

    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc_plus4 = r_id_pc4;
    assign id_imm16    = r_id_instr[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed per-cycle vectors, expected ID stream in a scoreboard queue
// popped by an independent monitor whenever ID hands an instruction on.
module tb_if_id_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [15:0] id_imm16;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc_plus4_2;
    logic [15:0] id_imm16_2;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    if_id_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc_plus4  (id_pc_plus4),
        .id_imm16     (id_imm16)
    );

    if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req2),
        .imem_addr    (imem_addr2),
        .imem_ack     (imem_ack2),
        .imem_rdata   (imem_rdata2),
        .stall        (1'b0),
        .flush        (1'b0),
        .branch_taken (1'b0),
        .branch_target(32'h0),
        .id_valid     (id_valid2),
        .id_instr     (id_instr2),
        .id_pc_plus4  (id_pc_plus4_2),
        .id_imm16     (id_imm16_2)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor: an instruction is handed on when ID holds it and nothing stalls or kills it.
    always @(negedge clk) begin
        if (rst_n && id_valid && !stall && !flush && !branch_taken) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: actual instr=%h required=none", id_instr);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_instr", id_instr, mon_e.instr);
                chk("sb_pc4", id_pc_plus4, mon_e.pc4);
                chk("sb_imm16", {16'h0, id_imm16}, {16'h0, mon_e.instr[15:0]});
            end
        end
    end

    // One cycle: drive at posedge+1, check fetch outputs at negedge.
    task automatic step(input string name, input logic ack, input logic [31:0] rd,
                        input logic st, input logic fl, input logic br,
                        input logic [31:0] tgt, input logic exp_req,
                        input logic [31:0] exp_addr, input logic push);
        imem_ack      = ack;
        imem_rdata    = rd;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = tgt;
        if (push) sb.push_back({rd, exp_addr + 32'd4});
        @(negedge clk);
        chk({name, "_req"}, {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) chk({name, "_addr"}, imem_addr, exp_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        stall        = 1'b0;
        flush        = 1'b0;
        branch_taken = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc4", id_pc_plus4, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ack2     = 1'b0;
        imem_rdata2   = 32'h0;
        @(posedge clk);
        #1;
        reset_dut();

        // Zero-wait streaming.
        step("t1_f0", 1'b1, 32'h2000_0001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b1);
        step("t1_f1", 1'b1, 32'h2000_0002, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1);
        step("t1_f2", 1'b1, 32'h2000_0003, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1);
        step("t1_f3", 1'b1, 32'h2000_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1);

        // Stall for 3 cycles with a fetch landing in the skid buffer.
        step("t2_s0", 1'b1, 32'h8C01_FFF0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
        step("t2_s1", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_held", id_instr, 32'h2000_0004);
        step("t2_s2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("t2_rel", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t2_buf_instr", id_instr, 32'h8C01_FFF0);
        chk("t2_buf_imm16", {16'h0, id_imm16}, 32'h0000_FFF0);
        step("t2_resume", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0);

        // Redirect while the fetch at 0x10 is still waiting.
        reset_dut();
        step("t3_f0", 1'b1, 32'h3000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b1);
        step("t3_f1", 1'b1, 32'h3000_0004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1);
        step("t3_f2", 1'b1, 32'h3000_0008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 1'b1);
        step("t3_f3", 1'b1, 32'h3000_000C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b0);
        step("t3_br", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h41, 1'b1, 32'h10, 1'b0);
        chk("t3_br_kill", {31'h0, id_valid}, 32'h0);
        step("t3_w2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        step("t3_w3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        step("t3_dack", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        chk("t3_drop", {31'h0, id_valid}, 32'h0);
        step("t3_f40", 1'b1, 32'h1111_0040, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
        step("t3_f44w", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0);

        // Flush in HOLD under stall: ID empties, buffered word follows once, not twice.
        step("t4_f44", 1'b1, 32'h2222_0044, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b0);
        step("t4_f48", 1'b1, 32'h3333_0048, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h48, 1'b1);
        step("t4_flush", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_flushed", {31'h0, id_valid}, 32'h0);
        step("t4_reload", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t4_reload_v", {31'h0, id_valid}, 32'h1);
        chk("t4_reload_i", id_instr, 32'h3333_0048);
        step("t4_f4c", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4C, 1'b0);
        chk("t4_nodup", {31'h0, id_valid}, 32'h0);

        // Reset while in HOLD with a valid stalled instruction.
        step("t5_f4c", 1'b1, 32'h4444_004C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4C, 1'b0);
        step("t5_f50", 1'b1, 32'h5555_0050, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h50, 1'b0);
        reset_dut();
        chk("t5_valid", {31'h0, id_valid}, 32'h0);
        step("t5_restart", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0);

        // PC wrap from RESET_PC = 0xFFFF_FFFC.
        imem_ack2   = 1'b1;
        imem_rdata2 = 32'h9999_0001;
        @(negedge clk);
        chk("t6_req0", {31'h0, imem_req2}, 32'h1);
        chk("t6_addr0", imem_addr2, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        imem_rdata2 = 32'h9999_0002;
        chk("t6_instr0", id_instr2, 32'h9999_0001);
        chk("t6_pc4_0", id_pc_plus4_2, 32'h0);
        @(negedge clk);
        chk("t6_addr1", imem_addr2, 32'h0);
        @(posedge clk);
        #1;
        imem_ack2 = 1'b0;
        chk("t6_instr1", id_instr2, 32'h9999_0002);
        chk("t6_pc4_1", id_pc_plus4_2, 32'h4);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
